// File: rtl/bootrom_pkg.sv
// Boot ROM overlay controller: shared types and address-map constants.
// Imported by the controller, its address map and the loader interface users.
package bootrom_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [15:0] FF50_ADDR = 16'hFF50;
    localparam logic [15:0] DMG_HI    = 16'h00FF;
    localparam logic [15:0] CGB_LO    = 16'h0200;
    localparam logic [15:0] CGB_HI    = 16'h08FF;
    localparam logic [15:0] CGB_OFF   = 16'h0100;

endpackage

// File: rtl/bootrom_ctrl_if.sv
// Byte-stream loader handshake feeding the boot RAM.
// The loader is the master; the boot controller is the slave.
interface bootrom_ctrl_if;

    logic       ld_start;
    logic       ld_valid;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       ld_done;

    modport master (
        output ld_start,
        output ld_valid,
        output ld_data,
        input  ld_ready,
        input  ld_done
    );

    modport slave (
        input  ld_start,
        input  ld_valid,
        input  ld_data,
        output ld_ready,
        output ld_done
    );

endinterface

// File: rtl/bootrom_addr_map.sv
// CPU address to boot RAM address translation for the DMG and CGB maps.
// Purely combinational; unmapped addresses translate to zero.
module bootrom_addr_map
    import bootrom_pkg::*;
#(
    parameter int RAM_AW = 11
) (
    input  logic [15:0]       cpu_addr,
    input  logic              is_gbc,
    output logic              hit,
    output logic [RAM_AW-1:0] ram_addr
);

    logic lo_hit;
    logic cgb_hit;

    assign lo_hit  = (cpu_addr <= DMG_HI);
    assign cgb_hit = is_gbc
                  && (cpu_addr >= CGB_LO)
                  && (cpu_addr <= CGB_HI);

    always_comb begin
        hit      = 1'b0;
        ram_addr = '0;
        unique case (1'b1)
            lo_hit: begin
                hit      = 1'b1;
                ram_addr = RAM_AW'(cpu_addr);
            end
            cgb_hit: begin
                hit      = 1'b1;
                ram_addr = RAM_AW'(cpu_addr - CGB_OFF);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/bootrom_ctrl.sv
// Boot ROM controller: streams the boot image into RAM port B, then
// overlays it onto the CPU map through port A until FF50 disables it.
module bootrom_ctrl
    import bootrom_pkg::*;
#(
    parameter int RAM_AW    = 11,
    parameter int DMG_BYTES = 256
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [15:0]       cpu_addr,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    input  logic [7:0]        cpu_di,
    input  logic              is_gbc,
    bootrom_ctrl_if.slave     ld,
    output logic [RAM_AW-1:0] ram_addr_a,
    input  logic [7:0]        ram_q_a,
    output logic [RAM_AW-1:0] ram_addr_b,
    output logic [7:0]        ram_data_b,
    output logic              ram_wren_b,
    output logic              boot_active,
    output logic              cpu_hold,
    output logic              boot_sel,
    output logic [7:0]        boot_do
);

    localparam logic [RAM_AW-1:0] DMG_LAST = RAM_AW'(DMG_BYTES - 1);

    state_t            state;
    logic [RAM_AW-1:0] cnt;
    logic [RAM_AW-1:0] last;
    logic              ready_q;
    logic              hold_q;
    logic              active_q;
    logic              sel_q;
    logic              map_hit;
    logic [RAM_AW-1:0] map_addr;
    logic              accept;
    logic              last_byte;
    logic              ff50_off;
    logic              unused_di;

    bootrom_addr_map #(
        .RAM_AW (RAM_AW)
    ) u_map (
        .cpu_addr (cpu_addr),
        .is_gbc   (is_gbc),
        .hit      (map_hit),
        .ram_addr (map_addr)
    );

    // reset_n gate keeps a reset cycle from leaking a stray write
    assign accept    = ld.ld_valid && ready_q && reset_n;
    assign last_byte = accept && (cnt == last);
    assign ff50_off  = cpu_wr && (cpu_addr == FF50_ADDR) && cpu_di[0];
    assign unused_di = ^cpu_di[7:1];

    assign ram_wren_b  = accept;
    assign ram_addr_b  = cnt;
    assign ram_data_b  = ld.ld_data;
    assign ld.ld_done  = last_byte;
    assign ld.ld_ready = ready_q;
    assign cpu_hold    = hold_q;
    assign boot_active = active_q;
    assign boot_sel    = sel_q;
    assign boot_do     = sel_q ? ram_q_a : 8'h00;
    assign ram_addr_a  = map_addr;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            last     <= DMG_LAST;
            ready_q  <= 1'b0;
            hold_q   <= 1'b1;
            active_q <= 1'b1;
            sel_q    <= 1'b0;
        end else begin
            // uses the pre-write active flag so a racing disable still hits
            sel_q <= cpu_rd && map_hit && active_q
                  && (state == ST_DONE);
            if (ff50_off)
                active_q <= 1'b0;
            if (ld.ld_start) begin
                state   <= ST_LOAD;
                cnt     <= '0;
                last    <= is_gbc ? '1 : DMG_LAST;
                ready_q <= 1'b1;
                hold_q  <= 1'b1;
            end else if (last_byte) begin
                state   <= ST_DONE;
                ready_q <= 1'b0;
                hold_q  <= 1'b0;
            end else if (accept) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bootrom_ctrl.sv
// Randomized bench for bootrom_ctrl with a RAM model and an image-level
// reference of the expected writes and overlay reads.
module tb_bootrom_ctrl;

    localparam int AW      = 11;
    localparam int DMG     = 256;
    localparam int CGB_LEN = 2048;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic [15:0]   cpu_addr;
    logic          cpu_rd;
    logic          cpu_wr;
    logic [7:0]    cpu_di;
    logic          is_gbc;
    logic [AW-1:0] ram_addr_a;
    logic [7:0]    ram_q_a;
    logic [AW-1:0] ram_addr_b;
    logic [7:0]    ram_data_b;
    logic          ram_wren_b;
    logic          boot_active;
    logic          cpu_hold;
    logic          boot_sel;
    logic [7:0]    boot_do;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:CGB_LEN-1];
    logic [7:0] exp_mem [0:CGB_LEN-1];

    always #5 clk_sys = ~clk_sys;

    bootrom_ctrl_if ld();

    bootrom_ctrl #(
        .RAM_AW    (AW),
        .DMG_BYTES (DMG)
    ) dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .cpu_addr    (cpu_addr),
        .cpu_rd      (cpu_rd),
        .cpu_wr      (cpu_wr),
        .cpu_di      (cpu_di),
        .is_gbc      (is_gbc),
        .ld          (ld),
        .ram_addr_a  (ram_addr_a),
        .ram_q_a     (ram_q_a),
        .ram_addr_b  (ram_addr_b),
        .ram_data_b  (ram_data_b),
        .ram_wren_b  (ram_wren_b),
        .boot_active (boot_active),
        .cpu_hold    (cpu_hold),
        .boot_sel    (boot_sel),
        .boot_do     (boot_do)
    );

    // dual-port boot RAM: registered read on A, write on B
    always @(posedge clk_sys) begin
        if (ram_wren_b)
            mem[ram_addr_b] <= ram_data_b;
        ram_q_a <= mem[ram_addr_a];
    end

    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic void model_map(input logic [15:0] a, input logic gbc,
                                      output logic hit, output int ra);
        hit = 1'b0;
        ra  = 0;
        if (int'(a) < 256) begin
            hit = 1'b1;
            ra  = int'(a);
        end else if (gbc && int'(a) >= 512 && int'(a) < 2304) begin
            hit = 1'b1;
            ra  = int'(a) - 256;
        end
    endfunction

    task automatic do_reset();
        reset_n     = 1'b0;
        ld.ld_start = 1'b0;
        ld.ld_valid = 1'b0;
        ld.ld_data  = 8'h00;
        cpu_rd      = 1'b0;
        cpu_wr      = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset_n = 1'b0;
        step();
        @(negedge clk_sys);
        tests += 6;
        if (ld.ld_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready got %b want 0", ld.ld_ready);
        end
        if (ld.ld_done !== 1'b0) begin
            fails++; $display("FAIL reset_done got %b want 0", ld.ld_done);
        end
        if (ram_wren_b !== 1'b0) begin
            fails++; $display("FAIL reset_wren got %b want 0", ram_wren_b);
        end
        if (cpu_hold !== 1'b1) begin
            fails++; $display("FAIL reset_hold got %b want 1", cpu_hold);
        end
        if (boot_active !== 1'b1) begin
            fails++; $display("FAIL reset_active got %b want 1", boot_active);
        end
        if (boot_sel !== 1'b0) begin
            fails++; $display("FAIL reset_sel got %b want 0", boot_sel);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_cgb_load();
        logic [21:0] got, exp;
        for (int i = 0; i < CGB_LEN; i++)
            exp_mem[i] = 8'($urandom);
        is_gbc      = 1'b1;
        ld.ld_start = 1'b1;
        step();
        ld.ld_start = 1'b0;
        ld.ld_valid = 1'b1;
        for (int k = 0; k < CGB_LEN; k++) begin
            ld.ld_data = exp_mem[k];
            @(negedge clk_sys);
            got = {ram_wren_b, ram_addr_b, ram_data_b, ld.ld_done, cpu_hold};
            exp = {1'b1, 11'(k), exp_mem[k], (k == CGB_LEN - 1), 1'b1};
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL cgb_write[%0d] got %h want %h", k, got, exp);
            end
            step();
        end
        ld.ld_valid = 1'b0;
        @(negedge clk_sys);
        tests++;
        if ({cpu_hold, ld.ld_ready} !== 2'b00) begin
            fails++;
            $display("FAIL cgb_after got %b%b want 00", cpu_hold, ld.ld_ready);
        end
        step();
    endtask

    task automatic test_reads(input logic gbc, input int n_rand);
        logic [15:0] list [$];
        logic        hit;
        int          ra;
        logic [7:0]  want_do;
        is_gbc = gbc;
        list   = '{16'h0005, 16'h0150, 16'h0300, 16'h00FF, 16'h08FF, 16'h0900};
        for (int i = 0; i < n_rand; i++)
            list.push_back(($urandom_range(0, 3) == 0) ? 16'($urandom)
                                                       : 16'($urandom_range(0, 16'h0A00)));
        foreach (list[i]) begin
            model_map(list[i], gbc, hit, ra);
            cpu_addr = list[i];
            cpu_rd   = 1'b1;
            @(negedge clk_sys);
            tests++;
            if (ram_addr_a !== 11'(ra)) begin
                fails++;
                $display("FAIL rd_addr[%h] got %h want %h", list[i], ram_addr_a, 11'(ra));
            end
            step();
            cpu_rd   = 1'b0;
            cpu_addr = 16'($urandom);
            want_do  = hit ? exp_mem[ra] : 8'h00;
            @(negedge clk_sys);
            tests++;
            if ({boot_sel, boot_do} !== {hit, want_do}) begin
                fails++;
                $display("FAIL rd_data[%h] got %b/%h want %b/%h",
                         list[i], boot_sel, boot_do, hit, want_do);
            end
            step();
        end
    endtask

    task automatic test_ff50();
        cpu_addr = 16'hFF50;
        cpu_di   = 8'($urandom) & 8'hFE;
        cpu_wr   = 1'b1;
        step();
        cpu_wr = 1'b0;
        @(negedge clk_sys);
        tests++;
        if (boot_active !== 1'b1) begin
            fails++; $display("FAIL ff50_even got %b want 1", boot_active);
        end
        step();
        cpu_addr = 16'h0005;
        cpu_rd   = 1'b1;
        step();
        cpu_rd   = 1'b0;
        cpu_addr = 16'hFF50;
        cpu_di   = 8'h11;
        cpu_wr   = 1'b1;
        @(negedge clk_sys);
        tests++;
        if ({boot_sel, boot_do} !== {1'b1, exp_mem[5]}) begin
            fails++;
            $display("FAIL ff50_race got %b/%h want 1/%h", boot_sel, boot_do, exp_mem[5]);
        end
        step();
        cpu_wr = 1'b0;
        @(negedge clk_sys);
        tests++;
        if (boot_active !== 1'b0) begin
            fails++; $display("FAIL ff50_off got %b want 0", boot_active);
        end
        cpu_addr = 16'h0000;
        cpu_rd   = 1'b1;
        step();
        cpu_rd = 1'b0;
        @(negedge clk_sys);
        tests++;
        if ({boot_sel, boot_do} !== 9'h000) begin
            fails++; $display("FAIL ff50_miss got %b/%h want 0/00", boot_sel, boot_do);
        end
        step();
        do_reset();
        @(negedge clk_sys);
        tests++;
        if (boot_active !== 1'b1) begin
            fails++; $display("FAIL ff50_rearm got %b want 1", boot_active);
        end
        step();
    endtask

    task automatic test_dmg_load();
        int         n = 0;
        int         seen = 0;
        logic [7:0] d;
        logic [21:0] got, exp;
        is_gbc      = 1'b0;
        ld.ld_start = 1'b1;
        step();
        ld.ld_start = 1'b0;
        is_gbc      = 1'b1;
        for (int c = 0; c < 2 * DMG + 20; c++) begin
            d           = 8'($urandom);
            ld.ld_valid = (c % 2 == 0);
            ld.ld_data  = d;
            @(negedge clk_sys);
            if (ram_wren_b === 1'b1)
                seen++;
            if (ld.ld_valid && n < DMG) begin
                got = {ram_wren_b, ram_addr_b, ram_data_b, ld.ld_done, cpu_hold};
                exp = {1'b1, 11'(n), d, (n == DMG - 1), 1'b1};
                exp_mem[n] = d;
                n++;
            end else begin
                got = {ram_wren_b, 20'h0, ld.ld_done, 1'b0};
                exp = 22'h0;
            end
            tests++;
            if (got !== exp) begin
                fails++;
                $display("FAIL dmg_cycle[%0d] got %h want %h", c, got, exp);
            end
            step();
        end
        ld.ld_valid = 1'b0;
        tests += 2;
        if (seen !== DMG) begin
            fails++; $display("FAIL dmg_count got %0d want %0d", seen, DMG);
        end
        if (cpu_hold !== 1'b0) begin
            fails++; $display("FAIL dmg_hold got %b want 0", cpu_hold);
        end
    endtask

    task automatic test_restart();
        do_reset();
        is_gbc      = 1'($urandom);
        ld.ld_start = 1'b1;
        step();
        ld.ld_start = 1'b0;
        ld.ld_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            ld.ld_data = 8'($urandom);
            step();
        end
        ld.ld_valid = 1'b0;
        ld.ld_start = 1'b1;
        step();
        ld.ld_start = 1'b0;
        ld.ld_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_sys);
            tests++;
            if ({ram_wren_b, ram_addr_b} !== {1'b1, 11'(k)}) begin
                fails++;
                $display("FAIL restart_addr[%0d] got %b/%h want 1/%h",
                         k, ram_wren_b, ram_addr_b, 11'(k));
            end
            step();
        end
        ld.ld_valid = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        is_gbc      = 1'b1;
        ld.ld_start = 1'b1;
        step();
        ld.ld_start = 1'b0;
        ld.ld_valid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            ld.ld_data = 8'($urandom);
            step();
        end
        reset_n = 1'b0;
        step();
        @(negedge clk_sys);
        tests++;
        if ({ram_wren_b, ld.ld_ready, cpu_hold, ld.ld_done} !== 4'b0010) begin
            fails++;
            $display("FAIL midrst_state got %b%b%b%b want 0010",
                     ram_wren_b, ld.ld_ready, cpu_hold, ld.ld_done);
        end
        reset_n = 1'b1;
        step();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk_sys);
            tests++;
            if (ram_wren_b !== 1'b0) begin
                fails++; $display("FAIL midrst_write[%0d] got %b want 0", k, ram_wren_b);
            end
            step();
        end
        ld.ld_valid = 1'b0;
    endtask

    initial begin
        cpu_addr = 16'h0000;
        cpu_di   = 8'h00;
        is_gbc   = 1'b0;
        test_reset();
        test_cgb_load();
        test_reads(1'b1, 24);
        test_ff50();
        test_dmg_load();
        test_reads(1'b0, 16);
        test_restart();
        test_reset_mid_load();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
